// File: rtl/demux_stream_router.sv
// 1-to-NUM_CH stream demux with one registered slot per channel; unicast, broadcast or counted drop.
// Latency 1 clk; in_ready falls only when a targeted slot is full and not draining.
module demux_stream_router #(
  parameter int DATA_W = 8,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = 2,
  parameter int CNT_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic                     in_bcast,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]         drop_cnt
);

  logic [NUM_CH-1:0]             valid_q, valid_d;
  logic [NUM_CH-1:0][DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]              drop_q, drop_d;

  logic [NUM_CH-1:0] ch_free;
  logic [NUM_CH-1:0] sel_hit;
  logic [NUM_CH-1:0] load;
  logic              sel_ok;
  logic              xfer;
  logic              drop;

  // One-hot decode; an out-of-range select simply hits no channel.
  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_hit[i] = (32'(in_sel) == 32'(i));
    end
  end

  assign sel_ok  = |sel_hit;
  assign ch_free = ~valid_q | out_ready;

  always_comb begin
    in_ready = 1'b0;
    if (rst_n) begin
      if (in_bcast) begin
        in_ready = &ch_free;
      end else if (sel_ok) begin
        in_ready = |(ch_free & sel_hit);
      end else begin
        in_ready = 1'b1;
      end
    end
  end

  assign xfer = in_valid & in_ready;
  assign load = xfer ? (in_bcast ? {NUM_CH{1'b1}} : sel_hit) : '0;
  assign drop = xfer & ~in_bcast & ~sel_ok;

  // Load wins over drain so a full slot can be refilled every cycle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    drop_d  = drop_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (load[i]) begin
        valid_d[i] = 1'b1;
        data_d[i]  = in_data;
      end else if (valid_q[i] && out_ready[i]) begin
        valid_d[i] = 1'b0;
      end
    end
    if (drop && (drop_q != {CNT_W{1'b1}})) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
      drop_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop_cnt  = drop_q;

endmodule
